modbus_rsp_tx: RTL and testbench
================================

// Module: modbus_rsp_tx
// PURPOSE
//  Modbus RTU slave response builder/transmitter; downstream of the request exception checker.
//  - On exception_done, builds either an exception response or a normal response (FC 03/04/06).
//  - Appends CRC-16/MODBUS and streams the frame byte-wise to the UART TX over a valid/ready handshake.
//  - Fetches register read data for FC 03/04 from the register file one word at a time.
// PARAMETERS
//  SLAVE_ADDR  8'h01  device address placed in byte 0 of every response
//  MAX_REGS    5      max quantity for FC 03/04; quantity 0 or >MAX_REGS sent as exception 03
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  exception_done in   1   1-cycle pulse: request validated, response required
//  exception      in   8   00 = normal response; else exception code (01/02/03)
//  func_code      in   8   request function code, valid with exception_done
//  addr           in   16  request start/register address, valid with exception_done
//  data           in   16  FC03/04: quantity; FC06: write value; valid with exception_done
//  rx_slave_addr  in   8   address byte of the received request
//  reg_rd_en      out  1   register read strobe
//  reg_rd_addr    out  16  register read address
//  reg_rd_data    in   16  read data, valid exactly 1 cycle after reg_rd_en
//  tx_data        out  8   byte to UART TX
//  tx_valid       out  1   tx_data valid
//  tx_ready       in   1   UART TX accepts byte; transfer = tx_valid & tx_ready
//  busy           out  1   frame in progress (LOAD..CRC_H)
//  rsp_done       out  1   1-cycle pulse after last CRC byte transferred
//  rsp_drop       out  1   1-cycle pulse: exception_done arrived while busy, ignored
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, CRC reg 16'hFFFF, counters 0; reset mid-frame aborts
//   immediately (tx_valid 0 next cycle, no rsp_done).
//  Capture: in IDLE, exception_done latches func_code/addr/data/exception/rx_slave_addr; state→LOAD.
//  Frames (CRC over all preceding bytes, CRC low byte sent first):
//   - exception!=0: SLAVE_ADDR, func_code|8'h80, exception, CRC_L, CRC_H (5 bytes).
//   - FC06, exception==0: echo SLAVE_ADDR,06,addr_hi,addr_lo,data_hi,data_lo,CRC_L,CRC_H.
//   - FC03/04, exception==0: SLAVE_ADDR, fc, byte_cnt=2*N, {reg_hi,reg_lo} x N, CRC.
//     reg_rd_addr = addr+i, i = 0..N-1; N = data[7:0].
//   - FC03/04 with N==0 or N>MAX_REGS: exception frame with code 03.
//   - FC not in {03,04,06} with exception==0: exception frame with code 01.
//  FSM: IDLE→LOAD→HDR→(RD_REQ→RD_WAIT→DATA_HI→DATA_LO)*N→CRC_L→CRC_H→DONE→IDLE.
//   - LOAD selects the frame type; HDR emits bytes from a byte index.
//   - RD_REQ asserts reg_rd_en for 1 cycle; RD_WAIT registers reg_rd_data.
//   - DONE pulses rsp_done for 1 cycle; busy=0 in IDLE only.
//  Handshake: tx_data and tx_valid held stable while tx_valid & !tx_ready.
//   - Advance/CRC update only on transfer.
//   - tx_valid may stay high back-to-back across bytes.
//  Latency: exception_done at cycle T → first byte valid at T+2; 1 byte/cycle when tx_ready=1,
//   except 2 extra cycles per register read.
//  CRC: init FFFF, reflected poly A001, byte-wise next-state function; reset to FFFF in LOAD.
//  Overlap: exception_done while busy → rsp_drop pulse; current frame unaffected.
//   exception_done in the same cycle as DONE is also dropped.
//  Address arithmetic: addr+i wraps modulo 2^16; byte_cnt = {N[6:0],1'b0}.
// CONFIGURATION
//  Macro RSP_BCAST_SILENT_EN:
//   - Defined: rx_slave_addr==8'h00 (broadcast) → no frame; IDLE→DONE, rsp_done still pulses,
//     tx_valid stays 0, no register reads.
//   - Undefined: broadcast is answered like a unicast request.
// STRUCTURE
//  Package mb_pkg: FC_RD_HOLD=8'h03, FC_RD_INPUT=8'h04, FC_WR_SINGLE=8'h06, EXC_ILL_FUNC=01,
//   EXC_ILL_ADDR=02, EXC_ILL_DATA=03, CRC_INIT=16'hFFFF, CRC_POLY=16'hA001, state enum.
//  Sub-module crc16_modbus_byte: combinational crc_in[15:0]+byte[7:0]→crc_out[15:0].
//   Shared with the RX frame checker.
// TESTING
//  1. FC03 with exception=02, tx_ready=1 → bytes 01 83 02 C0 F1, then rsp_done pulse.
//  2. FC06 addr=0001 data=0003, exc 00 → 01 06 00 01 00 03 98 0B.
//  3. FC04 addr=0001 N=2, regs 1/2 = 000A/0102 → 01 04 04 00 0A 01 02 + CRC (model);
//     reg_rd_addr sequence 0001, 0002.
//  4. FC06 with tx_ready toggled 1-of-3 cycles → identical byte stream; tx_data stable while stalled.
//  5. exception_done during frame → rsp_drop pulse; original frame bit-exact.
//     rst asserted mid-frame → tx_valid=0 next cycle, busy=0, no rsp_done.
//  6. rx_slave_addr=00 FC06 → with RSP_BCAST_SILENT_EN: no tx_valid, rsp_done pulse;
//     without the macro: full echo frame.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared Modbus RTU definitions: function/exception codes, CRC constants,
// and the response transmitter state and frame-kind encodings.
package mb_pkg;

    localparam logic [7:0]  FC_RD_HOLD   = 8'h03;
    localparam logic [7:0]  FC_RD_INPUT  = 8'h04;
    localparam logic [7:0]  FC_WR_SINGLE = 8'h06;

    localparam logic [7:0]  EXC_ILL_FUNC = 8'h01;
    localparam logic [7:0]  EXC_ILL_ADDR = 8'h02;
    localparam logic [7:0]  EXC_ILL_DATA = 8'h03;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'hA001;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_HDR     = 4'd2,
        ST_RD_REQ  = 4'd3,
        ST_RD_WAIT = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_DATA_LO = 4'd6,
        ST_CRC_L   = 4'd7,
        ST_CRC_H   = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    // Which fixed header layout the frame uses.
    typedef enum logic [1:0] {
        FR_EXC = 2'd0,
        FR_WR  = 2'd1,
        FR_RD  = 2'd2
    } frame_e;

endpackage

// File: rtl/crc16_modbus_byte.sv
// Combinational CRC-16/MODBUS byte step (reflected polynomial, LSB first).
// Also used by the RX frame checker.
module crc16_modbus_byte
    import mb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    // Fold the byte into the low half, then shift out eight bits.
    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/modbus_rsp_tx.sv
// Modbus RTU slave response builder/transmitter.
// Builds exception, write-echo (FC06) or register-read (FC03/04) responses,
// appends CRC-16/MODBUS (low byte first) and streams bytes over valid/ready.
// Optional build macro RSP_BCAST_SILENT_EN: broadcast requests (address 00)
// produce no frame, only an rsp_done pulse.
module modbus_rsp_tx
    import mb_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         MAX_REGS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_done,
    input  logic [7:0]  exception,
    input  logic [7:0]  func_code,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic [7:0]  rx_slave_addr,
    output logic        reg_rd_en,
    output logic [15:0] reg_rd_addr,
    input  logic [15:0] reg_rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        rsp_done,
    output logic        rsp_drop
);

    localparam logic [7:0] MAX_N = 8'(MAX_REGS);

    state_e      state_q, state_d;
    frame_e      frame_q, frame_d;
    logic [7:0]  fc_q, fc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  exc_q, exc_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  reg_idx_q, reg_idx_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        reg_rd_en_q, reg_rd_en_d;
    logic [15:0] reg_rd_addr_q, reg_rd_addr_d;
    logic        busy_q, busy_d;
    logic        rsp_done_q, rsp_done_d;
    logic        rsp_drop_q, rsp_drop_d;

    logic        xfer_s;
    logic        bcast_silent_s;
    logic [2:0]  hdr_last_s;
    logic [15:0] crc_nxt_s;

    // The byte being transferred is always the one folded into the CRC.
    crc16_modbus_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (tx_data_q),
        .crc_out (crc_nxt_s)
    );

`ifdef RSP_BCAST_SILENT_EN
    assign bcast_silent_s = (rx_slave_addr == 8'h00);
`else
    logic unused_rx_addr_s;
    assign unused_rx_addr_s = ^rx_slave_addr;
    assign bcast_silent_s   = 1'b0;
`endif

    assign xfer_s     = tx_valid_q & tx_ready;
    assign hdr_last_s = (frame_q == FR_WR) ? 3'd5 : 3'd2;

    // Header byte at index i for the selected frame layout.
    function automatic logic [7:0] hdr_byte(input frame_e fr, input logic [2:0] i,
                                            input logic [7:0] fc, input logic [15:0] a,
                                            input logic [15:0] d, input logic [7:0] exc);
        logic [7:0] b;
        case (i)
            3'd0:    b = SLAVE_ADDR;
            3'd1:    b = (fr == FR_EXC) ? (fc | 8'h80) : fc;
            3'd2:    b = (fr == FR_EXC) ? exc : ((fr == FR_RD) ? {d[6:0], 1'b0} : a[15:8]);
            3'd3:    b = a[7:0];
            3'd4:    b = d[15:8];
            3'd5:    b = d[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state and next-output computation for the response FSM.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        fc_d          = fc_q;
        addr_d        = addr_q;
        data_d        = data_q;
        exc_d         = exc_q;
        idx_d         = idx_q;
        reg_idx_d     = reg_idx_q;
        rd_lo_d       = rd_lo_q;
        crc_d         = crc_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        reg_rd_en_d   = 1'b0;
        reg_rd_addr_d = reg_rd_addr_q;
        rsp_done_d    = 1'b0;
        rsp_drop_d    = exception_done & (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (exception_done) begin
                    fc_d   = func_code;
                    addr_d = addr;
                    data_d = data;
                    exc_d  = exception;
                    if (bcast_silent_s) begin
                        state_d    = ST_DONE;
                        rsp_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Qualify the request; invalid quantity or function becomes an exception frame.
                if (exc_q != 8'h00) begin
                    frame_d = FR_EXC;
                end else if ((fc_q == FC_RD_HOLD) || (fc_q == FC_RD_INPUT)) begin
                    if ((data_q[7:0] == 8'h00) || (data_q[7:0] > MAX_N)) begin
                        frame_d = FR_EXC;
                        exc_d   = EXC_ILL_DATA;
                    end else begin
                        frame_d = FR_RD;
                    end
                end else if (fc_q == FC_WR_SINGLE) begin
                    frame_d = FR_WR;
                end else begin
                    frame_d = FR_EXC;
                    exc_d   = EXC_ILL_FUNC;
                end
                crc_d      = CRC_INIT;
                idx_d      = 3'd0;
                reg_idx_d  = 8'h00;
                tx_data_d  = SLAVE_ADDR;
                tx_valid_d = 1'b1;
                state_d    = ST_HDR;
            end
            ST_HDR: begin
                if (xfer_s) begin
                    crc_d = crc_nxt_s;
                    if (idx_q == hdr_last_s) begin
                        if (frame_q == FR_RD) begin
                            tx_valid_d    = 1'b0;
                            reg_rd_en_d   = 1'b1;
                            reg_rd_addr_d = addr_q;
                            state_d       = ST_RD_REQ;
                        end else begin
                            tx_data_d = crc_nxt_s[7:0];
                            state_d   = ST_CRC_L;
                        end
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = hdr_byte(frame_q, idx_q + 3'd1, fc_q, addr_q, data_q, exc_q);
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                tx_data_d  = reg_rd_data[15:8];
                rd_lo_d    = reg_rd_data[7:0];
                tx_valid_d = 1'b1;
                state_d    = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                if (xfer_s) begin
                    crc_d     = crc_nxt_s;
                    tx_data_d = rd_lo_q;
                    state_d   = ST_DATA_LO;
                end else begin
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_LO: begin
                if (xfer_s) begin
                    crc_d = crc_nxt_s;
                    if ((reg_idx_q + 8'd1) == data_q[7:0]) begin
                        tx_data_d = crc_nxt_s[7:0];
                        state_d   = ST_CRC_L;
                    end else begin
                        // Register address wraps modulo 2^16.
                        reg_idx_d     = reg_idx_q + 8'd1;
                        tx_valid_d    = 1'b0;
                        reg_rd_en_d   = 1'b1;
                        reg_rd_addr_d = addr_q + {8'h00, reg_idx_q + 8'd1};
                        state_d       = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_DATA_LO;
                end
            end
            ST_CRC_L: begin
                if (xfer_s) begin
                    tx_data_d = crc_q[15:8];
                    state_d   = ST_CRC_H;
                end else begin
                    state_d = ST_CRC_L;
                end
            end
            ST_CRC_H: begin
                if (xfer_s) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    rsp_done_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_CRC_H;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_q       <= FR_EXC;
            fc_q          <= 8'h00;
            addr_q        <= 16'h0000;
            data_q        <= 16'h0000;
            exc_q         <= 8'h00;
            idx_q         <= 3'd0;
            reg_idx_q     <= 8'h00;
            rd_lo_q       <= 8'h00;
            crc_q         <= CRC_INIT;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            reg_rd_en_q   <= 1'b0;
            reg_rd_addr_q <= 16'h0000;
            busy_q        <= 1'b0;
            rsp_done_q    <= 1'b0;
            rsp_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            fc_q          <= fc_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            exc_q         <= exc_d;
            idx_q         <= idx_d;
            reg_idx_q     <= reg_idx_d;
            rd_lo_q       <= rd_lo_d;
            crc_q         <= crc_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            reg_rd_en_q   <= reg_rd_en_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            busy_q        <= busy_d;
            rsp_done_q    <= rsp_done_d;
            rsp_drop_q    <= rsp_drop_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign reg_rd_addr = reg_rd_addr_q;
    assign busy        = busy_q;
    assign rsp_done    = rsp_done_q;
    assign rsp_drop    = rsp_drop_q;

endmodule

// File: tb/tb_modbus_rsp_tx.sv
// Scoreboard bench for modbus_rsp_tx: stimulus pushes expected bytes/reads,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_modbus_rsp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_done;
    logic [7:0]  exception;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  rx_slave_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        rsp_done;
    logic        rsp_drop;

    modbus_rsp_tx #(.SLAVE_ADDR(8'h01), .MAX_REGS(5)) dut (
        .clk(clk), .rst(rst), .exception_done(exception_done), .exception(exception),
        .func_code(func_code), .addr(addr), .data(data), .rx_slave_addr(rx_slave_addr),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .rsp_done(rsp_done), .rsp_drop(rsp_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_addr[$];
    int exp_done = 0;
    int exp_drop = 0;
    int done_seen = 0;
    int done_base = 0;
    bit mon_en = 1'b1;
    int rdy_mode = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit silent(input logic [7:0] rxa);
`ifdef RSP_BCAST_SILENT_EN
        return (rxa == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // Register file contents seen by the DUT.
    function automatic logic [15:0] regval(input logic [15:0] a);
        if (a == 16'h0001) return 16'h000A;
        if (a == 16'h0002) return 16'h0102;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC5};
    endfunction

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    // Reference: the full expected response for one request.
    task automatic model(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] exc, input logic [7:0] rxa);
        logic [7:0]  f[$];
        logic [7:0]  code;
        logic [15:0] crc;
        logic [15:0] v;
        int n;
        if (silent(rxa)) return;
        code = exc;
        n = d[7:0];
        if (code == 8'h00) begin
            if (fc == 8'h03 || fc == 8'h04) begin
                if (n == 0 || n > 5) code = 8'h03;
            end else if (fc != 8'h06) begin
                code = 8'h01;
            end
        end
        f.push_back(8'h01);
        if (code != 8'h00) begin
            f.push_back(fc | 8'h80);
            f.push_back(code);
        end else if (fc == 8'h06) begin
            f.push_back(fc); f.push_back(a[15:8]); f.push_back(a[7:0]);
            f.push_back(d[15:8]); f.push_back(d[7:0]);
        end else begin
            f.push_back(fc);
            f.push_back(8'(2 * n));
            for (int i = 0; i < n; i++) begin
                v = regval(a + 16'(i));
                exp_addr.push_back(a + 16'(i));
                f.push_back(v[15:8]);
                f.push_back(v[7:0]);
            end
        end
        crc = 16'hFFFF;
        foreach (f[i]) crc = crc_upd(crc, f[i]);
        f.push_back(crc[7:0]);
        f.push_back(crc[15:8]);
        foreach (f[i]) exp_bytes.push_back(f[i]);
    endtask

    // Flow control on the UART side.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Register file: data follows a read strobe by one cycle, garbage otherwise.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= regval(reg_rd_addr);
        else           reg_rd_data <= 16'($urandom);
    end

    // Monitor: compares every transfer, read strobe and pulse against the scoreboard.
    always @(negedge clk) begin
        if (rsp_done) done_seen++;
        if (!mon_en || rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_bytes.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
                else chk("tx_byte_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (reg_rd_en) begin
                if (exp_addr.size() > 0) chk("reg_rd_addr", 32'(reg_rd_addr), 32'(exp_addr.pop_front()));
                else chk("reg_rd_unexpected", 32'(reg_rd_addr), 32'hFFFF_FFFF);
            end
            if (rsp_done) begin
                chk("done_expected", 32'(exp_done > 0), 32'd1);
                chk("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
                if (exp_done > 0) exp_done--;
            end
            if (rsp_drop) begin
                chk("drop_expected", 32'(exp_drop > 0), 32'd1);
                if (exp_drop > 0) exp_drop--;
            end
        end
    end

    task automatic issue(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] exc, input logic [7:0] rxa, input bit use_model);
        int n;
        n = 0;
        while (busy && n < 500) begin @(posedge clk); #1; n++; end
        chk("idle_before_issue", 32'(busy), 32'd0);
        if (use_model) model(fc, a, d, exc, rxa);
        if (mon_en) exp_done++;
        done_base = done_seen;
        func_code = fc; addr = a; data = d; exception = exc; rx_slave_addr = rxa;
        exception_done = 1'b1;
        @(posedge clk); #1;
        exception_done = 1'b0;
        if (!silent(rxa)) chk("no_early_byte", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;
        if (!silent(rxa)) chk("first_byte_latency", 32'(tx_valid), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_seen == done_base && n < 3000) begin @(posedge clk); #1; n++; end
        chk("done_timeout", 32'(done_seen != done_base), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; exception_done = 1'b0; exception = 8'h00; func_code = 8'h00;
        addr = 16'h0000; data = 16'h0000; rx_slave_addr = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {29'd0, rsp_done, rsp_drop, reg_rd_en}, 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Exception frame, literal expectation.
        rdy_mode = 0;
        exp_bytes = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        issue(8'h03, 16'h0000, 16'h0001, 8'h02, 8'h01, 1'b0);
        wait_done();

        // FC06 echo, literal expectation.
        exp_bytes = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        issue(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01, 1'b0);
        wait_done();

        // FC04 two-register read.
        issue(8'h04, 16'h0001, 16'h0002, 8'h00, 8'h01, 1'b1);
        wait_done();

        // FC06 under 1-of-3 flow control.
        rdy_mode = 1;
        issue(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01, 1'b1);
        wait_done();

        // Overlapping request is dropped, frame unaffected.
        issue(8'h06, 16'h1234, 16'hBEEF, 8'h00, 8'h01, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        exp_drop++;
        func_code = 8'h03; addr = 16'h5555; data = 16'h0002; exception_done = 1'b1;
        @(posedge clk); #1;
        exception_done = 1'b0;
        wait_done();

        // Reset mid-frame aborts without rsp_done.
        rdy_mode = 0;
        mon_en = 1'b0;
        issue(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        done_base = done_seen;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_seen), 32'(done_base));
        mon_en = 1'b1;

        // Broadcast request.
        issue(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00, 1'b1);
        wait_done();

        // Randomized requests, including address wrap and invalid quantities.
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  fc, exc, rxa;
            logic [15:0] a, d;
            rdy_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 4))
                0:       fc = 8'h03;
                1:       fc = 8'h04;
                2:       fc = 8'h06;
                3:       fc = 8'h03;
                default: fc = 8'($urandom);
            endcase
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            d = 16'($urandom);
            if (fc == 8'h03 || fc == 8'h04) d[7:0] = 8'($urandom_range(0, 7));
            exc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'h00;
            rxa = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'h01;
            issue(fc, a, d, exc, rxa, 1'b1);
            wait_done();
        end

        chk("end_bytes_left", 32'(exp_bytes.size()), 32'd0);
        chk("end_reads_left", 32'(exp_addr.size()), 32'd0);
        chk("end_done_left", 32'(exp_done), 32'd0);
        chk("end_drop_left", 32'(exp_drop), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
